imem_fetch_port: RTL and testbench

- Parametrised, handshaked instruction memory for the MIPS datapath.
- Purpose: replaces the combinational word-indexed lookup with a pipelined read port.
  - Byte-addressed fetch requests in; registered, backpressure-aware responses out.
  - Alignment/range error reporting on every response.
- Side write port: programs the array at run time.
- Position: between the program counter/fetch stage and the IF/ID pipeline register.

---
 rtl/imem_fetch_port.sv | 153 +++++++++++++++
 tb/tb_imem_fetch_port.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_fetch_port.sv
// imem_fetch_port: run-time-writable instruction memory with a one-deep
// pipelined fetch port, valid/ready handshakes, error flags and error counter.
//
// Ports:
//   Clk, Reset_n                      clock, async active-low reset
//   Req_Valid/Req_Ready/Req_Addr      byte-addressed fetch request
//   Flush                             drop held response, block accept
//   Rsp_Valid/Rsp_Ready               response handshake
//   Rsp_Instruction/Rsp_Error         registered fetch result
//   Wr_En/Wr_Addr/Wr_Data             program-write port
//   Err_Count                         saturating count of error responses
module imem_fetch_port #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int DEPTH      = 128,
  parameter int INIT_MODE  = 1
) (
  input  logic                  Clk,
  input  logic                  Reset_n,
  input  logic                  Req_Valid,
  output logic                  Req_Ready,
  input  logic [ADDR_WIDTH-1:0] Req_Addr,
  input  logic                  Flush,
  output logic                  Rsp_Valid,
  input  logic                  Rsp_Ready,
  output logic [DATA_WIDTH-1:0] Rsp_Instruction,
  output logic                  Rsp_Error,
  input  logic                  Wr_En,
  input  logic [ADDR_WIDTH-1:0] Wr_Addr,
  input  logic [DATA_WIDTH-1:0] Wr_Data,
  output logic [7:0]            Err_Count
);

  localparam int IDX_W = $clog2(DEPTH);

  // one bit wider than the address so DEPTH*4 is always representable
  localparam logic [ADDR_WIDTH:0] LIMIT =
    (ADDR_WIDTH+1)'(DEPTH * 4);

  typedef enum logic {
    S_EMPTY = 1'b0,
    S_FULL  = 1'b1
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [DATA_WIDTH-1:0] r_data;
  logic                  r_err;
  logic [7:0]            r_cnt;

  logic                  w_req_ready;
  logic                  w_accept;
  logic                  w_load;
  logic                  w_rd_bad;
  logic [IDX_W-1:0]      w_rd_idx;
  logic [DATA_WIDTH-1:0] w_rd_word;
  logic                  w_wr_ok;
  logic [IDX_W-1:0]      w_wr_idx;
  logic                  w_cnt_inc;

  logic [DATA_WIDTH-1:0] w_words [DEPTH];

  // ---------------- address decode ----------------
  assign w_rd_bad = (Req_Addr[1:0] != 2'b00) ||
                    ({1'b0, Req_Addr} >= LIMIT);
  assign w_rd_idx = Req_Addr[IDX_W+1:2];

  assign w_wr_ok  = Wr_En &&
                    (Wr_Addr[1:0] == 2'b00) &&
                    ({1'b0, Wr_Addr} < LIMIT);
  assign w_wr_idx = Wr_Addr[IDX_W+1:2];

  // ---------------- storage ----------------
  // Per-word registers so each word carries its own time-zero value;
  // contents are deliberately outside the reset domain.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_word
    localparam logic [DATA_WIDTH-1:0] INIT_VAL =
      (INIT_MODE == 1) ? DATA_WIDTH'(gi * 3) : '0;

    logic [DATA_WIDTH-1:0] r_word = INIT_VAL;

    always_ff @(posedge Clk) begin
      if (w_wr_ok && (w_wr_idx == IDX_W'(gi))) begin
        r_word <= Wr_Data;
      end
    end

    assign w_words[gi] = r_word;
  end

  // Read is sampled on the accept edge, so a same-edge write to the
  // same word is returned as the old value.
  assign w_rd_word = w_rd_bad ? '0 : w_words[w_rd_idx];

  // ---------------- handshake ----------------
  assign w_req_ready = !Flush &&
                       ((r_state == S_EMPTY) || Rsp_Ready);
  assign w_accept    = Req_Valid && w_req_ready;

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    if (Flush) begin
      w_state_nxt = S_EMPTY;
    end else if (w_accept) begin
      w_state_nxt = S_FULL;
      w_load      = 1'b1;
    end else if (Rsp_Ready) begin
      w_state_nxt = S_EMPTY;
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state <= S_EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // ---------------- response register ----------------
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_data <= '0;
      r_err  <= 1'b0;
    end else if (w_load) begin
      r_data <= w_rd_word;
      r_err  <= w_rd_bad;
    end
  end

  // ---------------- error counter ----------------
  // A flushed response is never delivered, so it is not counted.
  assign w_cnt_inc = (r_state == S_FULL) && Rsp_Ready &&
                     r_err && !Flush && (r_cnt != 8'hFF);

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_cnt <= '0;
    end else if (w_cnt_inc) begin
      r_cnt <= r_cnt + 8'd1;
    end
  end

  // ---------------- outputs ----------------
  assign Req_Ready       = w_req_ready;
  assign Rsp_Valid       = (r_state == S_FULL);
  assign Rsp_Instruction = r_data;
  assign Rsp_Error       = r_err;
  assign Err_Count       = r_cnt;

endmodule

// File: tb/tb_imem_fetch_port.sv
// tb_imem_fetch_port: directed plus randomized checks of imem_fetch_port
// against a transaction-level model of the memory and response slot.
module tb_imem_fetch_port;

  localparam int DEPTH = 128;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        flush;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_instr;
  logic        rsp_err;
  logic        wr_en;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;
  logic [7:0]  err_count;

  int n_chk = 0;
  int n_err = 0;

  logic [31:0] m_mem [DEPTH];
  logic        m_valid;
  logic [31:0] m_data;
  logic        m_err;
  int          m_cnt;

  imem_fetch_port #(
    .DATA_WIDTH (32),
    .ADDR_WIDTH (32),
    .DEPTH      (DEPTH),
    .INIT_MODE  (1)
  ) dut (
    .Clk             (clk),
    .Reset_n         (rst_n),
    .Req_Valid       (req_valid),
    .Req_Ready       (req_ready),
    .Req_Addr        (req_addr),
    .Flush           (flush),
    .Rsp_Valid       (rsp_valid),
    .Rsp_Ready       (rsp_ready),
    .Rsp_Instruction (rsp_instr),
    .Rsp_Error       (rsp_err),
    .Wr_En           (wr_en),
    .Wr_Addr         (wr_addr),
    .Wr_Data         (wr_data),
    .Err_Count       (err_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic addr_bad(input logic [31:0] a);
    return (a % 4 != 0) || (a >= DEPTH * 4);
  endfunction

  // one clock: predict from the current inputs, then compare after the edge
  task automatic tick();
    logic        rdy;
    logic        acc;
    logic        bad;
    logic [31:0] rd;
    #1;
    rdy = !flush && (!m_valid || rsp_ready);
    chk("req_ready", {31'd0, req_ready}, {31'd0, rdy});
    acc = req_valid && rdy;
    bad = addr_bad(req_addr);
    rd  = bad ? 32'd0 : m_mem[req_addr / 4];
    if (m_valid && rsp_ready && m_err && !flush && m_cnt < 255)
      m_cnt++;
    if (flush) begin
      m_valid = 1'b0;
    end else if (acc) begin
      m_valid = 1'b1;
      m_data  = rd;
      m_err   = bad;
    end else if (rsp_ready) begin
      m_valid = 1'b0;
    end
    if (wr_en && !addr_bad(wr_addr))
      m_mem[wr_addr / 4] = wr_data;
    @(posedge clk);
    #1;
    chk("rsp_valid", {31'd0, rsp_valid}, {31'd0, m_valid});
    chk("err_count", {24'd0, err_count}, 32'(m_cnt));
    if (m_valid) begin
      chk("rsp_instr", rsp_instr, m_data);
      chk("rsp_err", {31'd0, rsp_err}, {31'd0, m_err});
    end
  endtask

  task automatic idle();
    req_valid = 1'b0;
    flush     = 1'b0;
    wr_en     = 1'b0;
  endtask

  task automatic req(input logic [31:0] a);
    req_valid = 1'b1;
    req_addr  = a;
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) m_mem[i] = 32'(i * 3);
    m_valid = 1'b0;
    m_data  = '0;
    m_err   = 1'b0;
    m_cnt   = 0;

    rst_n     = 1'b0;
    req_addr  = '0;
    rsp_ready = 1'b1;
    wr_addr   = '0;
    wr_data   = '0;
    idle();

    // reset state
    #2;
    chk("rst_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_instr", rsp_instr, 32'd0);
    chk("rst_err", {31'd0, rsp_err}, 32'd0);
    chk("rst_count", {24'd0, err_count}, 32'd0);
    chk("rst_ready", {31'd0, req_ready}, 32'd1);
    #6 rst_n = 1'b1;

    // init readback, back-to-back
    req(32'h0); tick();
    chk("init0", rsp_instr, 32'd0);
    req(32'h4); tick();
    chk("init1", rsp_instr, 32'd3);
    req(32'h8); tick();
    chk("init2", rsp_instr, 32'd6);
    req(32'h10); tick();

    // backpressure
    rsp_ready = 1'b0;
    req(32'h14);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("bp_hold", rsp_instr, 32'd12);
      chk("bp_ready", {31'd0, req_ready}, 32'd0);
    end
    rsp_ready = 1'b1;
    tick();
    chk("bp_next", rsp_instr, 32'd15);

    // errors
    req(32'h200); tick();
    chk("oor_err", {31'd0, rsp_err}, 32'd1);
    chk("oor_data", rsp_instr, 32'd0);
    req(32'h6); tick();
    chk("mis_err", {31'd0, rsp_err}, 32'd1);
    req(32'h1FC); tick();
    chk("err_cnt2", {24'd0, err_count}, 32'd2);
    chk("last_word", rsp_instr, 32'd381);

    // write / collision
    req(32'h20);
    wr_en = 1'b1; wr_addr = 32'h20; wr_data = 32'hDEADBEEF;
    tick();
    chk("coll_old", rsp_instr, 32'd24);
    wr_en = 1'b0;
    tick();
    chk("coll_new", rsp_instr, 32'hDEADBEEF);
    req_valid = 1'b0;
    wr_en = 1'b1; wr_addr = 32'h22; wr_data = 32'h12345678;
    tick();
    wr_en = 1'b0;
    req(32'h20); tick();
    chk("mis_wr_20", rsp_instr, 32'hDEADBEEF);
    req(32'h24); tick();
    chk("mis_wr_24", rsp_instr, 32'd27);

    // flush over a held response
    req(32'h8); tick();
    rsp_ready = 1'b0;
    tick();
    chk("fl_full", rsp_instr, 32'd6);
    flush = 1'b1;
    #1 chk("fl_ready", {31'd0, req_ready}, 32'd0);
    tick();
    chk("fl_empty", {31'd0, rsp_valid}, 32'd0);
    chk("fl_cnt", {24'd0, err_count}, 32'd2);
    flush = 1'b0;

    // flushed error response is not counted
    rsp_ready = 1'b1;
    req(32'h1); tick();
    req_valid = 1'b0;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("fl_err_cnt", {24'd0, err_count}, 32'd2);

    // async reset with an error response pending
    req(32'h3); tick();
    req_valid = 1'b0;
    rsp_ready = 1'b0;
    tick();
    rst_n = 1'b0;
    #1;
    m_valid = 1'b0; m_data = '0; m_err = 1'b0; m_cnt = 0;
    chk("ar_valid", {31'd0, rsp_valid}, 32'd0);
    chk("ar_err", {31'd0, rsp_err}, 32'd0);
    chk("ar_cnt", {24'd0, err_count}, 32'd0);
    chk("ar_instr", rsp_instr, 32'd0);
    #1 rst_n = 1'b1;
    rsp_ready = 1'b1;
    req(32'h20); tick();
    chk("ar_keep", rsp_instr, 32'hDEADBEEF);

    // counter saturation
    for (int i = 0; i < 260; i++) begin
      req(32'h3); tick();
    end
    chk("sat", {24'd0, err_count}, 32'd255);
    req_valid = 1'b0;

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      int r;
      req_valid = ($urandom_range(0, 3) != 0);
      rsp_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 15) == 0);
      r = $urandom_range(0, 9);
      if (r < 7)      req_addr = 32'($urandom_range(0, DEPTH-1)) * 4;
      else if (r < 9) req_addr = $urandom;
      else            req_addr = 32'($urandom_range(0, 511)) | 32'h1;
      wr_en   = ($urandom_range(0, 3) == 0);
      wr_addr = ($urandom_range(0, 7) == 0) ? $urandom
              : 32'($urandom_range(0, DEPTH-1)) * 4;
      wr_data = $urandom;
      tick();
    end
    idle();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
